// File: rtl/invpd_sched.sv
// Two-requester scheduler in front of a serial modular-inverse datapath (P^-1 mod 2^W).
// Keeps a one-entry result cache, a round-robin arbiter and a WAIT watchdog.
module invpd_sched #(
    parameter int TIMEOUT = 80,
    parameter int W       = 65
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic         req1,
    input  logic [W-1:0] p0,
    input  logic [W-1:0] p1,
    input  logic         cache_clr,
    output logic         done0,
    output logic         done1,
    output logic [W-1:0] res,
    output logic         err,
    output logic         busy,
    output logic         invpd_load,
    output logic [W-1:0] invpd_inP,
    input  logic         invpd_ready,
    input  logic [W-1:0] invpd_out,
    output logic [1:0]   dbg_state
);

    localparam int WDW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_DONE} state_t;

    state_t         r_state;
    state_t         w_next;
    logic           r_id;
    logic [W-1:0]   r_p;
    logic [W-1:0]   r_res;
    logic           r_err;
    logic [W-1:0]   r_inp;
    logic           r_cv;
    logic [W-1:0]   r_cp;
    logic [W-1:0]   r_cres;
    logic           r_last;
    logic [WDW-1:0] r_wd;

    logic           w_any;
    logic           w_both;
    logic           w_gnt;
    logic [W-1:0]   w_p;
    logic           w_hit;
    logic           w_capture;
    logic           w_timeout;

    // r_last remembers the winner of the last contention only; lone requests leave it alone.
    always_comb begin
        w_any     = req0 | req1;
        w_both    = req0 & req1;
        w_gnt     = w_both ? ~r_last : req1;
        w_p       = w_gnt ? p1 : p0;
        w_hit     = r_cv && (r_cp == w_p);
        w_capture = (r_state == S_WAIT) && (r_wd != '0) && invpd_ready;
        w_timeout = (r_state == S_WAIT) && (r_wd == WDW'(TIMEOUT - 2));
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    if (!w_p[0] || w_hit) w_next = S_DONE;
                    else                  w_next = S_LOAD;
                end
            end
            S_LOAD:  w_next = S_WAIT;
            S_WAIT:  if (w_capture || w_timeout) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_id    <= 1'b0;
            r_p     <= '0;
            r_res   <= '0;
            r_err   <= 1'b0;
            r_inp   <= '0;
            r_last  <= 1'b1;
            r_wd    <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_id  <= w_gnt;
                        r_p   <= w_p;
                        r_err <= ~w_p[0];
                        r_res <= (w_p[0] && w_hit) ? r_cres : '0;
                        if (w_both) r_last <= w_gnt;
                        if (w_p[0] && !w_hit) r_inp <= w_p;
                    end
                end
                S_LOAD: r_wd <= '0;
                S_WAIT: begin
                    r_wd <= r_wd + WDW'(1);
                    if (w_capture) begin
                        r_res <= invpd_out;
                        r_err <= 1'b0;
                    end else if (w_timeout) begin
                        r_res <= '0;
                        r_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // A clear in the capture cycle beats the write, so the fresh result goes uncached.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cv   <= 1'b0;
            r_cp   <= '0;
            r_cres <= '0;
        end else if (cache_clr) begin
            r_cv   <= 1'b0;
        end else if (w_capture) begin
            r_cv   <= 1'b1;
            r_cp   <= r_p;
            r_cres <= invpd_out;
        end
    end

    always_comb begin
        done0      = (r_state == S_DONE) && !r_id;
        done1      = (r_state == S_DONE) &&  r_id;
        res        = (r_state == S_DONE) ? r_res : '0;
        err        = (r_state == S_DONE) && r_err;
        busy       = (r_state != S_IDLE);
        invpd_load = (r_state == S_LOAD);
        invpd_inP  = r_inp;
        dbg_state  = r_state;
    end

endmodule

// File: tb/tb_invpd_sched.sv
// Bench for invpd_sched: a behavioural inverse datapath, a one-entry cache model,
// and directed plus randomized requests checked with immediate assertions.
module tb_invpd_sched;

  localparam int TIMEOUT = 80;
  localparam int W = 65;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic req0 = 1'b0, req1 = 1'b0, cache_clr = 1'b0;
  logic [W-1:0] p0 = '0, p1 = '0;
  logic done0, done1, err, busy, invpd_load, invpd_ready;
  logic [W-1:0] res, invpd_inP, invpd_out;
  logic [1:0] dbg_state;

  invpd_sched #(.TIMEOUT(TIMEOUT), .W(W)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .p0(p0), .p1(p1),
    .cache_clr(cache_clr), .done0(done0), .done1(done1), .res(res), .err(err),
    .busy(busy), .invpd_load(invpd_load), .invpd_inP(invpd_inP),
    .invpd_ready(invpd_ready), .invpd_out(invpd_out), .dbg_state(dbg_state)
  );

  // Inverse mod 2^65 by Newton iteration; each step doubles the correct low bits.
  function automatic logic [64:0] inv65(input logic [64:0] p);
    logic [64:0] x, two;
    two = 65'd2;
    x = p;
    for (int i = 0; i < 7; i++) x = x * (two - p * x);
    return x;
  endfunction

  // Datapath model: ready rises 64 cycles after the load cycle (i.e. in cycle 65).
  int dp_cnt = 0;
  logic [W-1:0] dp_val = '0;
  bit m_stall = 0;
  always_ff @(posedge clk) begin
    if (invpd_load) begin
      dp_cnt <= 1;
      dp_val <= inv65(invpd_inP);
    end else if (dp_cnt != 0 && dp_cnt < 64) begin
      dp_cnt <= dp_cnt + 1;
    end
  end
  assign invpd_ready = !m_stall && (dp_cnt == 64);
  assign invpd_out = dp_val;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference model state: one cache entry and the last contention winner.
  bit m_cv = 0;
  logic [64:0] m_cp = '0, m_cres = '0;
  bit m_last = 1;

  task automatic model_reset();
    m_cv = 0;
    m_last = 1;
  endtask

  task automatic model_serve(input logic [64:0] p, input bit clr_at_cap,
                             output int lat, output logic [64:0] r, output logic e,
                             output bit miss);
    miss = 0;
    if (!p[0]) begin
      lat = 1; r = '0; e = 1'b1;
    end else if (m_cv && m_cp == p) begin
      lat = 1; r = m_cres; e = 1'b0;
    end else begin
      miss = 1;
      if (m_stall) begin
        lat = 1 + TIMEOUT; r = '0; e = 1'b1;
      end else begin
        lat = 66; r = inv65(p); e = 1'b0;
        if (clr_at_cap) m_cv = 0;
        else begin
          m_cv = 1; m_cp = p; m_cres = r;
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic run_req(input string tag, input bit id, input logic [64:0] p,
                         input bit clr_at_cap);
    int lat, load_cyc, done_cyc, clr_cyc;
    logic [64:0] r, got_res;
    logic e, got_err;
    bit miss, quiet_ok, other_done;
    model_serve(p, clr_at_cap, lat, r, e, miss);
    exp_q.push_back(r);
    clr_cyc = clr_at_cap ? 65 : -1;
    load_cyc = -1; done_cyc = -1; quiet_ok = 1; other_done = 0;
    got_res = '0; got_err = 1'b0;
    @(negedge clk);
    if (id) begin p1 = p; req1 = 1'b1; end
    else begin p0 = p; req0 = 1'b1; end
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (invpd_load && load_cyc < 0) load_cyc = n;
      if ((id ? done0 : done1)) other_done = 1;
      if ((id ? done1 : done0)) begin
        done_cyc = n; got_res = res; got_err = err;
        req0 = 1'b0; req1 = 1'b0; cache_clr = 1'b0;
        break;
      end
      if (res !== '0 || err !== 1'b0) quiet_ok = 0;
      cache_clr = (n == clr_cyc);
    end
    check({tag, "_lat"}, 65'(done_cyc), 65'(lat));
    check({tag, "_res"}, got_res, exp_q.pop_front());
    check({tag, "_err"}, 65'(got_err), 65'(e));
    check({tag, "_load"}, 65'(load_cyc), miss ? 65'd1 : {65{1'b1}});
    check({tag, "_quiet"}, 65'(quiet_ok && !other_done), 65'd1);
    if (miss && !e) check({tag, "_prod"}, p * got_res, 65'd1);
  endtask

  task automatic run_pair(input string tag, input logic [64:0] pa, input logic [64:0] pb);
    int lat_f, lat_s, c0, c1;
    logic [64:0] r_f, r_s, g0, g1;
    logic e_f, e_s;
    bit first, miss;
    first = m_last ? 1'b0 : 1'b1;
    m_last = first;
    model_serve(first ? pb : pa, 0, lat_f, r_f, e_f, miss);
    model_serve(first ? pa : pb, 0, lat_s, r_s, e_s, miss);
    c0 = -1; c1 = -1; g0 = '0; g1 = '0;
    @(negedge clk);
    p0 = pa; p1 = pb; req0 = 1'b1; req1 = 1'b1;
    for (int n = 1; n <= 400; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (done0 && c0 < 0) begin c0 = n; g0 = res; req0 = 1'b0; end
      if (done1 && c1 < 0) begin c1 = n; g1 = res; req1 = 1'b0; end
      if (c0 >= 0 && c1 >= 0) break;
    end
    req0 = 1'b0; req1 = 1'b0;
    check({tag, "_c0"}, 65'(c0), first ? 65'(lat_f + 1 + lat_s) : 65'(lat_f));
    check({tag, "_c1"}, 65'(c1), first ? 65'(lat_f) : 65'(lat_f + 1 + lat_s));
    check({tag, "_r0"}, g0, first ? r_s : r_f);
    check({tag, "_r1"}, g1, first ? r_f : r_s);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    cache_clr = 1'b1;
    @(negedge clk);
    cache_clr = 1'b0;
    m_cv = 0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [64:0] pool[3];
    logic [95:0] t;
    logic [64:0] pr;
    bit stray;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_busy", 65'(busy), 65'd0);
    check("rst_done", 65'({done0, done1}), 65'd0);
    check("rst_res", res, 65'd0);
    check("rst_err", 65'(err), 65'd0);
    check("rst_load", 65'(invpd_load), 65'd0);
    check("rst_inp", invpd_inP, 65'd0);
    rst = 1'b0;
    @(negedge clk);

    run_pair("cont1", 65'd11, 65'd13);
    run_pair("cont2", 65'd13, 65'd13);

    run_req("p1_miss", 1'b0, 65'd1, 0);
    run_req("p3_miss", 1'b1, 65'd3, 0);
    run_req("p3_hit", 1'b1, 65'd3, 0);
    run_req("even", 1'b0, 65'h10, 0);
    run_req("p3_hit2", 1'b0, 65'd3, 0);
    check("inp_hold", invpd_inP, 65'd3);

    run_req("clr_cap", 1'b0, 65'd21, 1);
    run_req("clr_cap_re", 1'b0, 65'd21, 0);

    m_stall = 1;
    run_req("wdog", 1'b1, 65'd7, 0);
    m_stall = 0;
    run_req("wdog_re", 1'b1, 65'd7, 0);

    // Reset during WAIT: nothing may complete afterwards.
    @(negedge clk);
    p0 = 65'd9; req0 = 1'b1;
    repeat (20) @(negedge clk);
    check("mid_busy", 65'(busy), 65'd1);
    rst = 1'b1; req0 = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", 65'(busy), 65'd0);
    rst = 1'b0;
    model_reset();
    stray = 0;
    repeat (80) begin
      @(negedge clk);
      if (done0 || done1 || busy) stray = 1;
    end
    check("mid_no_done", 65'(stray), 65'd0);
    run_req("post_rst", 1'b0, 65'd5, 0);

    // Randomized requests over a small pool so hits, misses and clears interleave.
    for (int i = 0; i < 3; i++) begin
      t = {$urandom(), $urandom(), $urandom()};
      pool[i] = t[64:0] | 65'd1;
    end
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 3) == 0) pulse_clr();
      pr = pool[$urandom_range(0, 2)];
      if ($urandom_range(0, 5) == 0) pr[0] = 1'b0;
      run_req($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), pr, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/invpd_sched.md
INVPD_SCHED -- requirements
Module: invpd_sched

Interface
REQ-001 Parameter TIMEOUT, default 80, watchdog limit in cycles from load to invpd_ready.
REQ-002 Parameter W, default 65, operand/result width; fixed to match the serial inverse datapath.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req0, req1  input  1 each  level request from requester 0/1; held high until its done pulse.
REQ-006 p0, p1  input  W each  odd modulus P from requester 0/1; stable while the matching req is high.
REQ-007 cache_clr  input  1  single-cycle pulse invalidating the result cache.
REQ-008 done0, done1  output  1 each  one-cycle completion pulse to requester 0/1.
REQ-009 res  output  W  result P^-1 mod 2^W; valid only while a done pulse is high.
REQ-010 err  output  1  error flag; valid only while a done pulse is high.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 invpd_load  output  1  load/start strobe to the inverse datapath (drives its rst pin).
REQ-013 invpd_inP  output  W  modulus to the inverse datapath; sampled there while invpd_load is high.
REQ-014 invpd_ready  input  1  datapath finished flag; high once its bit counter reaches 65.
REQ-015 invpd_out  input  W  datapath result.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD, WAIT and DONE.
REQ-017 IDLE: if any req is high, grant one requester, latch its P and id, and evaluate in the same cycle, in priority order: P even -> DONE with err=1; cache hit (cache valid and latched-P match) -> DONE with the cached result; otherwise -> LOAD.
REQ-018 Arbitration SHALL be round-robin: with both requests high, grant the requester not granted last; a single request is granted directly; last_grant SHALL reset to 1, so req0 wins the first contention.
REQ-019 LOAD: hold invpd_load=1 for exactly one cycle with invpd_inP equal to the latched P, clear the watchdog, go to WAIT.
REQ-020 WAIT: ignore invpd_ready in the first WAIT cycle; on invpd_ready=1, capture invpd_out, write the cache (valid=1, P, result) and go to DONE.
REQ-021 WAIT watchdog: if invpd_ready is not seen within TIMEOUT cycles of LOAD, go to DONE with err=1, res=0 and no cache write.
REQ-022 DONE: pulse done0 or done1 for the granted id for one cycle with res and err valid, then return to IDLE.
REQ-023 A requester that still holds req high in the cycle after its done pulse SHALL be treated as a new request.
REQ-024 Miss latency: request seen in IDLE at cycle 0 -> LOAD at cycle 1 -> done pulse at cycle 66.
REQ-025 Hit or even-P latency: request seen in IDLE at cycle 0 -> done pulse at cycle 1; invpd_load stays low.
REQ-026 cache_clr SHALL clear cache valid in any state; if it coincides with a WAIT capture, the clear wins and the result is returned but not cached.
REQ-027 Requests arriving while busy SHALL wait, unacknowledged; none are dropped.
REQ-028 Outside DONE, res SHALL be 0, err 0, and done0 and done1 0.
REQ-029 invpd_inP SHALL hold its last value when invpd_load is low.

Reset
REQ-030 On rst: state IDLE; busy, done0, done1, err and invpd_load 0; res and invpd_inP 0; cache valid 0; last_grant 1; watchdog 0.
REQ-031 rst asserted mid-operation SHALL abort without any done pulse; the datapath needs no reset because the next LOAD restarts it.

Verification
REQ-032 req0 with p0=1 -> invpd_load pulse at cycle 1, done0 at cycle 66, res=1, err=0.
REQ-033 req1 with p1=3 -> done1 at cycle 66, err=0, and (3*res) mod 2^65 = 1; repeat req1 with p1=3 -> done1 at cycle 1, same res, no invpd_load.
REQ-034 req0 and req1 asserted in the same cycle after reset -> req0 served first, then req1; the next contention serves req1 first.
REQ-035 req0 with p0=0x10 -> done0 at cycle 1, err=1, no invpd_load; cache contents unchanged.
REQ-036 invpd_ready held 0 by the bench -> done pulse at cycle 1+TIMEOUT (81 at default), err=1, res=0.
REQ-037 rst pulsed during WAIT, then req0 with p0=5 -> no stale done pulse; fresh miss with done0 at cycle 66 and (5*res) mod 2^65 = 1.
